// File: rtl/text_grid_renderer.sv
// Character-cell text renderer: beam position -> text cell -> glyph ROM lookup -> RGB444,
// with a power-up/reset clear of the text buffer and a blinking inverse cursor.
//
// state   | meaning
// S_CLEAR | filling every buffer cell with a space, one per clk; host writes dropped
// S_IDLE  | buffer ready; host writes accepted, pixels coloured normally
module text_grid_renderer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 60,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        vid_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_char,
  input  logic [12:0] cursor_addr,
  input  logic        cursor_en,
  output logic        busy,
  output logic [7:0]  char_sel,
  output logic [2:0]  char_x,
  output logic [2:0]  char_y,
  input  logic        glyph_pixel,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int          NCELLS     = COLS * ROWS;
  localparam logic [12:0] LAST_IDX   = 13'(NCELLS - 1);
  localparam logic [12:0] NCELLS13   = 13'(NCELLS);
  localparam logic [12:0] COLS13     = 13'(COLS);
  localparam logic [7:0]  COLS8      = 8'(COLS);
  localparam logic [7:0]  ROWS8      = 8'(ROWS);
  localparam int          BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t state, state_nxt;

  logic [12:0] clr_idx;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  text_mem [NCELLS];

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = 8'd32;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        mem_we = !rst;
        if (clr_idx == LAST_IDX) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (wr_en && (wr_addr < NCELLS13)) begin
          mem_we    = !rst;
          mem_waddr = wr_addr;
          mem_wdata = wr_char;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                        clr_idx <= '0;
    else if (state == S_CLEAR && clr_idx != LAST_IDX) clr_idx <= clr_idx + 13'd1;
  end

  // Non-blocking write with a registered read elsewhere gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (mem_we) text_mem[mem_waddr] <= mem_wdata;
  end

  logic [7:0]  col, row;
  logic        in_text_c;
  logic [12:0] addr_c;

  assign col       = hc[10:3];
  assign row       = vc[10:3];
  assign in_text_c = (col < COLS8) && (row < ROWS8);
  assign addr_c    = {5'b0, row} * COLS13 + {5'b0, col};

  logic        vid_s1, in_text_s1, hs_s1, vs_s1;
  logic [2:0]  gx_s1, gy_s1;
  logic [12:0] addr_s1;
  logic        vid_s2, in_text_s2, hs_s2, vs_s2;
  logic [2:0]  gx_s2;
  logic [12:0] addr_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_s1 <= 1'b0; in_text_s1 <= 1'b0; hs_s1 <= 1'b1; vs_s1 <= 1'b1;
      gx_s1 <= '0; gy_s1 <= '0; addr_s1 <= '0;
      vid_s2 <= 1'b0; in_text_s2 <= 1'b0; hs_s2 <= 1'b1; vs_s2 <= 1'b1;
      gx_s2 <= '0; addr_s2 <= '0;
      char_sel <= 8'd32; char_x <= '0; char_y <= '0;
    end else begin
      vid_s1     <= vid_on;
      in_text_s1 <= in_text_c;
      hs_s1      <= hsync_in;
      vs_s1      <= vsync_in;
      gx_s1      <= hc[2:0];
      gy_s1      <= vc[2:0];
      addr_s1    <= in_text_c ? addr_c : '0;
      vid_s2     <= vid_s1;
      in_text_s2 <= in_text_s1;
      hs_s2      <= hs_s1;
      vs_s2      <= vs_s1;
      gx_s2      <= gx_s1;
      addr_s2    <= addr_s1;
      char_sel   <= text_mem[addr_s1];
      char_x     <= (gx_s1 < 3'd5) ? gx_s1 : 3'd0;
      char_y     <= gy_s1;
    end
  end

  // Blink phase advances on the trailing (rising) edge of each active-low vsync pulse.
  logic          vs_prev, blink_phase;
  logic [BW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev <= 1'b1; frame_cnt <= '0; blink_phase <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          frame_cnt <= frame_cnt + BW'(1);
        end
      end
    end
  end

  logic        cursor_hit, pix;
  logic [11:0] rgb_nxt;

  assign cursor_hit = cursor_en && (addr_s2 == cursor_addr);
  assign pix        = glyph_pixel ^ (cursor_hit & blink_phase);

  always_comb begin
    rgb_nxt = BG_COLOR;
    if (busy || !vid_s2)                     rgb_nxt = 12'h000;
    else if (!in_text_s2 || gx_s2 >= 3'd5)   rgb_nxt = BG_COLOR;
    else                                     rgb_nxt = pix ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= 12'h000; hsync_out <= 1'b1; vsync_out <= 1'b1;
    end else begin
      rgb <= rgb_nxt; hsync_out <= hs_s2; vsync_out <= vs_s2;
    end
  end

endmodule

// File: tb/tb_text_grid_renderer.sv
// Scoreboard bench for text_grid_renderer: stimulus queues expected values tagged with
// the cycle they must appear; a negedge monitor pops and compares them.
module tb_text_grid_renderer;

  logic        clk = 1'b0;
  logic        rst, vid_on, hsync_in, vsync_in, wr_en, cursor_en, glyph_pixel;
  logic [10:0] hc, vc;
  logic [12:0] wr_addr, cursor_addr;
  logic [7:0]  wr_char, char_sel;
  logic [2:0]  char_x, char_y;
  logic        busy, hsync_out, vsync_out;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  // Glyph ROM stand-in: space is blank, every other glyph lights all columns except 2.
  assign glyph_pixel = (char_sel != 8'd32) && (char_x != 3'd2);

  text_grid_renderer dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .vid_on(vid_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .cursor_addr(cursor_addr), .cursor_en(cursor_en), .busy(busy),
    .char_sel(char_sel), .char_x(char_x), .char_y(char_y), .glyph_pixel(glyph_pixel),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  typedef struct {
    int          cyc;
    int          fld;
    logic [11:0] exp;
    string       nm;
  } chk_t;

  localparam int F_RGB = 0, F_SEL = 1, F_X = 2, F_Y = 3, F_BUSY = 4, F_HS = 5, F_VS = 6;

  chk_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int dly, input int fld, input logic [11:0] v, input string nm);
    chk_t e;
    int   i;
    e.cyc = cyc + dly; e.fld = fld; e.exp = v; e.nm = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > e.cyc) i--;
    q.insert(i, e);
  endtask

  always @(negedge clk) begin
    chk_t        e;
    logic [11:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.fld)
        F_RGB:   act = rgb;
        F_SEL:   act = {4'h0, char_sel};
        F_X:     act = {9'h0, char_x};
        F_Y:     act = {9'h0, char_y};
        F_BUSY:  act = {11'h0, busy};
        F_HS:    act = {11'h0, hsync_out};
        default: act = {11'h0, vsync_out};
      endcase
      total++;
      if (e.cyc != cyc || act !== e.exp) begin
        bad++;
        $display("FAIL %s at cyc %0d (due %0d): got %h want %h", e.nm, cyc, e.cyc, act, e.exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one beam position; char outputs are due 2 clk later, rgb 3 clk later.
  task automatic pix(input int h, input int v, input logic vid, input int sel,
                     input int x, input int y, input logic [11:0] col, input string nm);
    hc = 11'(h); vc = 11'(v); vid_on = vid;
    if (sel >= 0) begin
      expect_at(2, F_SEL, 12'(sel), {nm, ".sel"});
      expect_at(2, F_X,   12'(x),   {nm, ".x"});
      expect_at(2, F_Y,   12'(y),   {nm, ".y"});
    end
    expect_at(3, F_RGB, col, {nm, ".rgb"});
    tick();
  endtask

  task automatic vs_pulses(input int n);
    repeat (n) begin
      vsync_in = 1'b0; tick(2);
      vsync_in = 1'b1; tick(2);
    end
  endtask

  int r;

  initial begin
    rst = 1'b1; hc = '0; vc = '0; vid_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_char = '0; cursor_addr = '0; cursor_en = 1'b0;
    tick(2);
    expect_at(0, F_RGB, 12'h000, "rst.rgb");
    expect_at(0, F_SEL, 12'd32,  "rst.sel");
    expect_at(0, F_X,   12'd0,   "rst.x");
    expect_at(0, F_Y,   12'd0,   "rst.y");
    expect_at(0, F_BUSY, 12'd1,  "rst.busy");
    expect_at(0, F_HS,  12'd1,   "rst.hs");
    expect_at(0, F_VS,  12'd1,   "rst.vs");

    rst = 1'b0; hsync_in = 1'b1; hc = 11'd1; vc = 11'd0; vid_on = 1'b1;
    r = cyc;
    for (int i = 1; i <= 3; i++) expect_at(i, F_HS, 12'd1, "rel.hs");
    expect_at(1,    F_BUSY, 12'd1, "clr.busy_start");
    expect_at(4799, F_BUSY, 12'd1, "clr.busy_last");
    expect_at(4800, F_BUSY, 12'd0, "clr.busy_done");
    expect_at(10,   F_RGB, 12'h000, "clr.rgb10");
    expect_at(2000, F_RGB, 12'h000, "clr.rgb2000");
    expect_at(4800, F_RGB, 12'h000, "clr.rgb4800");
    tick(4801);

    pix(632, 472, 1'b1, 32, 0, 0, 12'h000, "clr_last");
    pix(320, 240, 1'b1, 32, 0, 0, 12'h000, "clr_mid");
    pix(0,   0,   1'b1, 32, 0, 0, 12'h000, "clr_first");

    wr_en = 1'b1; wr_addr = 13'd0; wr_char = 8'd65;
    tick();
    wr_en = 1'b0;
    pix(1, 0, 1'b1, 65, 1, 0, 12'hFFF, "a_x1");
    pix(2, 0, 1'b1, 65, 2, 0, 12'h000, "a_x2");
    pix(3, 3, 1'b1, 65, 3, 3, 12'hFFF, "a_x3y3");
    pix(5, 0, 1'b1, 65, 0, 0, 12'h000, "gap5");
    pix(6, 1, 1'b1, 65, 0, 1, 12'h000, "gap6");
    pix(7, 7, 1'b1, 65, 0, 7, 12'h000, "gap7");
    pix(640, 0, 1'b1, -1, 0, 0, 12'h000, "col80");
    pix(0, 480, 1'b1, -1, 0, 0, 12'h000, "row60");
    pix(700, 0, 1'b0, -1, 0, 0, 12'h000, "blank");

    pix(8, 0, 1'b1, 32, 0, 0, 12'h000, "rf_old");
    wr_en = 1'b1; wr_addr = 13'd1; wr_char = 8'd66;
    pix(8, 0, 1'b1, 66, 0, 0, 12'hFFF, "rf_new");
    wr_en = 1'b0;

    wr_en = 1'b1; wr_addr = 13'd4800; wr_char = 8'd90;
    tick();
    wr_en = 1'b0;
    pix(0, 0, 1'b1, 65, 0, 0, 12'hFFF, "oor_write");

    hsync_in = 1'b0;
    expect_at(2, F_HS, 12'd1, "hs.pre");
    expect_at(3, F_HS, 12'd0, "hs.lo0");
    expect_at(4, F_HS, 12'd0, "hs.lo1");
    expect_at(5, F_HS, 12'd1, "hs.post");
    tick(2);
    hsync_in = 1'b1;
    tick(4);

    cursor_en = 1'b1; cursor_addr = 13'd81;
    pix(8, 8, 1'b1, 32, 0, 0, 12'h000, "cur_off");
    tick(3);
    expect_at(3, F_VS, 12'd0, "vs.dly");
    vs_pulses(29);
    pix(8, 8, 1'b1, 32, 0, 0, 12'h000, "cur_29");
    tick(3);
    vs_pulses(1);
    pix(8,  8,  1'b1, 32, 0, 0, 12'hFFF, "cur_on_tl");
    pix(10, 9,  1'b1, 32, 2, 1, 12'hFFF, "cur_on_x2");
    pix(12, 15, 1'b1, 32, 4, 7, 12'hFFF, "cur_on_br");
    pix(13, 8,  1'b1, 32, 0, 0, 12'h000, "cur_gap");
    pix(16, 8,  1'b1, 32, 0, 0, 12'h000, "cur_nbr");
    pix(0,  0,  1'b1, 65, 0, 0, 12'hFFF, "cur_other");
    tick(4);
    cursor_en = 1'b0;
    pix(8, 8, 1'b1, 32, 0, 0, 12'h000, "cur_dis");
    tick(4);
    cursor_en = 1'b1;
    vs_pulses(30);
    pix(8, 8, 1'b1, 32, 0, 0, 12'h000, "cur_60");
    tick(4);
    cursor_en = 1'b0;

    rst = 1'b1; tick(2);
    rst = 1'b0;
    tick(1000);
    rst = 1'b1; tick(2);
    rst = 1'b0;
    expect_at(1,    F_BUSY, 12'd1, "reclr.busy_start");
    expect_at(4799, F_BUSY, 12'd1, "reclr.busy_last");
    expect_at(4800, F_BUSY, 12'd0, "reclr.busy_done");
    expect_at(100,  F_RGB, 12'h000, "reclr.rgb");
    tick(1500);
    wr_en = 1'b1; wr_addr = 13'd5; wr_char = 8'd90;
    tick();
    wr_en = 1'b0;
    tick(3300);
    pix(40, 0, 1'b1, 32, 0, 0, 12'h000, "busy_wr");
    pix(0,  0, 1'b1, 32, 0, 0, 12'h000, "reclr_cell0");
    pix(8,  0, 1'b1, 32, 0, 0, 12'h000, "reclr_cell1");

    tick(6);
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries want 0", q.size());
      total += q.size();
      bad   += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
